// File: rtl/fpu_dispatch_pkg.sv
// Shared definitions for the FPU queue dispatcher.
//   - dispatch_state_e : dispatcher FSM states
//   - EXC_*            : exception_code encodings
//   - DEFAULT_OPC_*    : default internal opcodes of the serializing instructions
//   - issue_entry_t    : one queue entry as held in the issue register
//   - is_serializing() : true for opcodes that must drain the queue after retire
package fpu_dispatch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } dispatch_state_e;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ERROR   = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

    localparam logic [7:0] DEFAULT_OPC_FINIT = 8'hE3;
    localparam logic [7:0] DEFAULT_OPC_FLDCW = 8'hD9;

    typedef struct packed {
        logic [7:0]  instruction;
        logic [2:0]  stack_index;
        logic        has_memory_op;
        logic [1:0]  operand_size;
        logic        is_integer;
        logic        is_bcd;
        logic [79:0] data;
    } issue_entry_t;

    // FINIT and FLDCW change control state, so younger entries fetched
    // under the old state must be discarded once they retire.
    function automatic logic is_serializing(input logic [7:0] opc,
                                            input logic [7:0] opc_finit,
                                            input logic [7:0] opc_fldcw);
        return (opc == opc_finit) || (opc == opc_fldcw);
    endfunction

endpackage

// File: rtl/fpu_dispatch_watchdog.sv
// Watchdog counter for an in-flight NEU instruction.
//   clk, reset  : clock, synchronous active-high reset
//   clear_i     : force the count to 0 (has priority over enable_i)
//   enable_i    : advance the count by one this cycle
//   terminal_o  : count has reached TIMEOUT_CYCLES-1
// TIMEOUT_CYCLES must lie in 1..65535 so the terminal value fits in 16 bits.
module fpu_dispatch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == TERMINAL);

endmodule

// File: rtl/fpu_queue_dispatcher.sv
// Drains the FPU instruction queue one entry at a time into the NEU core.
//   Queue side : queue_empty, q_* head fields in; dequeue, flush_queue out
//   NEU side   : exec_start and held exec_* fields out; exec_done, exec_error in
//   Control    : dispatch_enable gates new pops; exception_clear releases HALT
//   Status     : busy, exception_pending, exception_code, retired_count
// A popped entry is captured in the issue register and stays stable until the
// next pop. FINIT/FLDCW retire through FLUSH; faults and watchdog timeouts
// flush the queue and park in HALT until software clears them.
module fpu_queue_dispatcher
    import fpu_dispatch_pkg::*;
#(
    parameter logic [7:0]  OPC_FINIT      = DEFAULT_OPC_FINIT,
    parameter logic [7:0]  OPC_FLDCW      = DEFAULT_OPC_FLDCW,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dispatch_enable,
    input  logic        queue_empty,
    input  logic [7:0]  q_instruction,
    input  logic [2:0]  q_stack_index,
    input  logic        q_has_memory_op,
    input  logic [1:0]  q_operand_size,
    input  logic        q_is_integer,
    input  logic        q_is_bcd,
    input  logic [79:0] q_data,
    output logic        dequeue,
    output logic        flush_queue,
    output logic        exec_start,
    output logic [7:0]  exec_instruction,
    output logic [2:0]  exec_stack_index,
    output logic        exec_has_memory_op,
    output logic [1:0]  exec_operand_size,
    output logic        exec_is_integer,
    output logic        exec_is_bcd,
    output logic [79:0] exec_data,
    input  logic        exec_done,
    input  logic        exec_error,
    output logic        busy,
    output logic        exception_pending,
    output logic [1:0]  exception_code,
    input  logic        exception_clear,
    output logic [15:0] retired_count
);

    dispatch_state_e state_q, state_d;
    issue_entry_t    issue_q, issue_d;
    logic [1:0]      exc_code_q, exc_code_d;
    logic [15:0]     retired_q, retired_d;

    logic pop;
    logic wd_clear;
    logic wd_enable;
    logic wd_terminal;

    fpu_dispatch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (wd_clear),
        .enable_i   (wd_enable),
        .terminal_o (wd_terminal)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        issue_d     = issue_q;
        exc_code_d  = exc_code_q;
        retired_d   = retired_q;
        pop         = 1'b0;
        flush_queue = 1'b0;
        exec_start  = 1'b0;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;

        unique case (state_q)
            IDLE: begin
                pop = !queue_empty && dispatch_enable;
                if (pop) begin
                    issue_d.instruction   = q_instruction;
                    issue_d.stack_index   = q_stack_index;
                    issue_d.has_memory_op = q_has_memory_op;
                    issue_d.operand_size  = q_operand_size;
                    issue_d.is_integer    = q_is_integer;
                    issue_d.is_bcd        = q_is_bcd;
                    issue_d.data          = q_data;
                    state_d               = ISSUE;
                end
            end
            ISSUE: begin
                // exec_done is deliberately ignored here: the core has not
                // seen the start pulse yet.
                exec_start = 1'b1;
                wd_clear   = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                wd_enable = 1'b1;
                // A completion arriving on the terminal cycle still wins.
                if (exec_done) begin
                    if (exec_error) begin
                        flush_queue = 1'b1;
                        exc_code_d  = EXC_ERROR;
                        state_d     = HALT;
                    end else begin
                        retired_d = retired_q + 16'd1;
                        state_d   = is_serializing(issue_q.instruction, OPC_FINIT, OPC_FLDCW)
                                    ? FLUSH : IDLE;
                    end
                end else if (wd_terminal) begin
                    flush_queue = 1'b1;
                    exc_code_d  = EXC_TIMEOUT;
                    state_d     = HALT;
                end
            end
            FLUSH: begin
                flush_queue = 1'b1;
                state_d     = IDLE;
            end
            HALT: begin
                if (exception_clear) begin
                    exc_code_d = EXC_NONE;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            exc_code_q <= EXC_NONE;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            exc_code_q <= exc_code_d;
            retired_q  <= retired_d;
        end
    end

    assign dequeue            = pop;
    assign busy               = (state_q != IDLE);
    assign exception_pending  = (state_q == HALT);
    assign exception_code     = exc_code_q;
    assign retired_count      = retired_q;

    assign exec_instruction   = issue_q.instruction;
    assign exec_stack_index   = issue_q.stack_index;
    assign exec_has_memory_op = issue_q.has_memory_op;
    assign exec_operand_size  = issue_q.operand_size;
    assign exec_is_integer    = issue_q.is_integer;
    assign exec_is_bcd        = issue_q.is_bcd;
    assign exec_data          = issue_q.data;

endmodule

// File: tb/tb_fpu_queue_dispatcher.sv
// Directed bench for fpu_queue_dispatcher (watchdog shortened to 8 cycles).
// Inputs change on the falling edge; outputs are checked shortly after.
module tb_fpu_queue_dispatcher;

    localparam logic [7:0] OPC_FINIT = 8'hE3;
    localparam logic [7:0] OPC_FLDCW = 8'hD9;

    typedef struct packed {
        logic [7:0]  ins;
        logic [2:0]  idx;
        logic        mem;
        logic [1:0]  sz;
        logic        intg;
        logic        bcd;
        logic [79:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_enable;
    logic        queue_empty;
    logic [7:0]  q_instruction;
    logic [2:0]  q_stack_index;
    logic        q_has_memory_op;
    logic [1:0]  q_operand_size;
    logic        q_is_integer;
    logic        q_is_bcd;
    logic [79:0] q_data;
    logic        dequeue;
    logic        flush_queue;
    logic        exec_start;
    logic [7:0]  exec_instruction;
    logic [2:0]  exec_stack_index;
    logic        exec_has_memory_op;
    logic [1:0]  exec_operand_size;
    logic        exec_is_integer;
    logic        exec_is_bcd;
    logic [79:0] exec_data;
    logic        exec_done;
    logic        exec_error;
    logic        busy;
    logic        exception_pending;
    logic [1:0]  exception_code;
    logic        exception_clear;
    logic [15:0] retired_count;

    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;
    int     exp_retired = 0;
    int     start_cyc;
    int     last_start;
    entry_t exp_q[$];

    always #5 clk = ~clk;

    fpu_queue_dispatcher #(
        .OPC_FINIT      (OPC_FINIT),
        .OPC_FLDCW      (OPC_FLDCW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .dispatch_enable    (dispatch_enable),
        .queue_empty        (queue_empty),
        .q_instruction      (q_instruction),
        .q_stack_index      (q_stack_index),
        .q_has_memory_op    (q_has_memory_op),
        .q_operand_size     (q_operand_size),
        .q_is_integer       (q_is_integer),
        .q_is_bcd           (q_is_bcd),
        .q_data             (q_data),
        .dequeue            (dequeue),
        .flush_queue        (flush_queue),
        .exec_start         (exec_start),
        .exec_instruction   (exec_instruction),
        .exec_stack_index   (exec_stack_index),
        .exec_has_memory_op (exec_has_memory_op),
        .exec_operand_size  (exec_operand_size),
        .exec_is_integer    (exec_is_integer),
        .exec_is_bcd        (exec_is_bcd),
        .exec_data          (exec_data),
        .exec_done          (exec_done),
        .exec_error         (exec_error),
        .busy               (busy),
        .exception_pending  (exception_pending),
        .exception_code     (exception_code),
        .exception_clear    (exception_clear),
        .retired_count      (retired_count)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Present a head entry in IDLE, expect the pop, then expect the start
    // pulse carrying exactly that entry. Returns at the ISSUE cycle.
    task automatic issue_entry(input logic [7:0] opc, input logic [79:0] data,
                               input logic keep_nonempty, output int start_at);
        entry_t e;
        entry_t got;
        e.ins  = opc;
        e.idx  = opc[2:0];
        e.mem  = opc[3];
        e.sz   = opc[5:4];
        e.intg = opc[6];
        e.bcd  = opc[7];
        e.data = data;
        q_instruction   = e.ins;
        q_stack_index   = e.idx;
        q_has_memory_op = e.mem;
        q_operand_size  = e.sz;
        q_is_integer    = e.intg;
        q_is_bcd        = e.bcd;
        q_data          = e.data;
        queue_empty     = 1'b0;
        #1;
        check("dequeue_idle", dequeue, 1'b1);
        check("flush_with_dequeue", flush_queue, 1'b0);
        exp_q.push_back(e);
        tick();
        if (!keep_nonempty) queue_empty = 1'b1;
        #1;
        start_at = cyc;
        check("exec_start", exec_start, 1'b1);
        check("dequeue_in_issue", dequeue, 1'b0);
        got = {exec_instruction, exec_stack_index, exec_has_memory_op,
               exec_operand_size, exec_is_integer, exec_is_bcd, exec_data};
        e = exp_q.pop_front();
        check("issue_header", got[95:80], e[95:80]);
        check("issue_data", got[79:0], e.data);
    endtask

    initial begin
        reset = 1'b1; dispatch_enable = 1'b1; queue_empty = 1'b1;
        q_instruction = '0; q_stack_index = '0; q_has_memory_op = 1'b0;
        q_operand_size = '0; q_is_integer = 1'b0; q_is_bcd = 1'b0; q_data = '0;
        exec_done = 1'b0; exec_error = 1'b0; exception_clear = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_busy", busy, 1'b0);
        check("rst_start", exec_start, 1'b0);
        check("rst_flush", flush_queue, 1'b0);
        check("rst_pending", exception_pending, 1'b0);
        check("rst_code", exception_code, 2'b00);
        check("rst_retired", retired_count, 16'd0);
        check("rst_data", exec_data, 80'd0);
        reset = 1'b0;
        #1;
        check("idle_empty_no_dequeue", dequeue, 1'b0);

        // 1: basic issue, done two cycles after start
        issue_entry(8'h10, 80'h1234, 1'b0, start_cyc);
        tick();
        check("t1_start_one_cycle", exec_start, 1'b0);
        check("t1_data_held_w1", exec_data, 80'h1234);
        check("t1_busy", busy, 1'b1);
        tick();
        exec_done = 1'b1;
        #1;
        check("t1_data_held_w2", exec_data, 80'h1234);
        check("t1_no_flush", flush_queue, 1'b0);
        tick();
        exec_done = 1'b0;
        exp_retired++;
        #1;
        check("t1_retired", retired_count, 16'(exp_retired));
        check("t1_idle", busy, 1'b0);
        check("t1_data_kept", exec_data, 80'h1234);

        // 2: three back-to-back entries, immediate done
        for (int i = 0; i < 3; i++) begin
            issue_entry(8'h11 + 8'(i), 80'hA000 + 80'(i), 1'b1, start_cyc);
            if (i > 0) check("t2_start_spacing", 80'(start_cyc - last_start), 80'd3);
            last_start = start_cyc;
            exec_done = 1'b1;
            tick();
            #1;
            check("t2_no_flush", flush_queue, 1'b0);
            tick();
            exec_done = 1'b0;
            exp_retired++;
            #1;
            check("t2_retired", retired_count, 16'(exp_retired));
        end
        queue_empty = 1'b1;

        // 3: FINIT retires with two younger entries still queued
        issue_entry(OPC_FINIT, 80'h5, 1'b1, start_cyc);
        q_instruction = 8'h20;
        tick();
        exec_done = 1'b1;
        #1;
        check("t3_no_flush_in_wait", flush_queue, 1'b0);
        tick();
        exec_done = 1'b0;
        exp_retired++;
        #1;
        check("t3_flush", flush_queue, 1'b1);
        check("t3_no_dequeue_in_flush", dequeue, 1'b0);
        check("t3_retired", retired_count, 16'(exp_retired));
        tick();
        queue_empty = 1'b1;
        #1;
        check("t3_flush_one_cycle", flush_queue, 1'b0);
        check("t3_idle", busy, 1'b0);

        // 4: execution error
        issue_entry(8'h21, 80'hBEEF, 1'b0, start_cyc);
        tick();
        exec_done = 1'b1; exec_error = 1'b1;
        #1;
        check("t4_flush", flush_queue, 1'b1);
        tick();
        exec_done = 1'b0; exec_error = 1'b0; queue_empty = 1'b0;
        #1;
        check("t4_pending", exception_pending, 1'b1);
        check("t4_code", exception_code, 2'b01);
        check("t4_retired_same", retired_count, 16'(exp_retired));
        check("t4_no_dequeue_halt", dequeue, 1'b0);
        tick();
        #1;
        check("t4_still_halted", exception_pending, 1'b1);
        queue_empty = 1'b1;
        exception_clear = 1'b1;
        tick();
        exception_clear = 1'b0;
        #1;
        check("t4_clear_pending", exception_pending, 1'b0);
        check("t4_clear_code", exception_code, 2'b00);
        check("t4_clear_idle", busy, 1'b0);

        // 5a: watchdog timeout, NEU never answers
        issue_entry(8'h30, 80'h77, 1'b0, start_cyc);
        tick();
        for (int k = 1; k < 8; k++) begin
            #1;
            check("t5_no_early_flush", flush_queue, 1'b0);
            tick();
        end
        #1;
        check("t5_timeout_flush", flush_queue, 1'b1);
        check("t5_timeout_delay", 80'(cyc - start_cyc), 80'd8);
        tick();
        #1;
        check("t5_code", exception_code, 2'b10);
        check("t5_pending", exception_pending, 1'b1);
        exception_clear = 1'b1;
        tick();
        exception_clear = 1'b0;
        #1;
        check("t5_cleared", exception_code, 2'b00);

        // 5b: done on the terminal cycle retires normally (FLDCW serializes)
        issue_entry(OPC_FLDCW, 80'h99, 1'b0, start_cyc);
        tick();
        for (int k = 1; k < 8; k++) tick();
        exec_done = 1'b1;
        #1;
        check("t5b_no_timeout_flush", flush_queue, 1'b0);
        tick();
        exec_done = 1'b0;
        exp_retired++;
        #1;
        check("t5b_code", exception_code, 2'b00);
        check("t5b_retired", retired_count, 16'(exp_retired));
        check("t5b_fldcw_flush", flush_queue, 1'b1);
        check("t5b_not_halted", exception_pending, 1'b0);
        tick();
        #1;
        check("t5b_idle", busy, 1'b0);

        // 6a: reset during WAIT
        issue_entry(8'h40, 80'hDEAD, 1'b0, start_cyc);
        tick();
        reset = 1'b1;
        tick();
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ins", exec_instruction, 8'h00);
        check("t6_rst_data", exec_data, 80'd0);
        check("t6_rst_retired", retired_count, 16'd0);
        check("t6_rst_start", exec_start, 1'b0);
        check("t6_rst_flush", flush_queue, 1'b0);
        reset = 1'b0;
        exp_retired = 0;

        // 6b: dispatch disabled with a non-empty queue
        dispatch_enable = 1'b0;
        queue_empty     = 1'b0;
        q_instruction   = 8'h50;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6_disabled_no_dequeue", dequeue, 1'b0);
            check("t6_disabled_idle", busy, 1'b0);
            tick();
        end
        dispatch_enable = 1'b1;
        issue_entry(8'h50, 80'h4242, 1'b0, start_cyc);
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        exp_retired++;
        #1;
        check("t6_retired", retired_count, 16'(exp_retired));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_queue_dispatcher.md
Name: fpu_queue_dispatcher

Overview:
- Drains the 3-entry FPU instruction queue and issues one entry at a time to the NEU execution core.
- Holds each issued entry stable in an issue register until the core reports completion.
- Serializes FINIT and FLDCW, and raises a queue flush on those instructions, on execution errors and on watchdog timeout.
- Sits between the queue dequeue port and the NEU start/done interface.

Parameters:
- OPC_FINIT, 8'hE3: internal opcode of FINIT; a serializing instruction.
- OPC_FLDCW, 8'hD9: internal opcode of FLDCW; a serializing instruction.
- TIMEOUT_CYCLES, 1023: maximum WAIT cycles before the watchdog fires. Legal range 1..65535.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- dispatch_enable, in, 1: when 0, no new entry is popped. An in-flight instruction still completes.
- queue_empty, in, 1: queue has no entries.
- q_instruction, in, 8: queue head opcode.
- q_stack_index, in, 3: queue head stack index.
- q_has_memory_op, in, 1: queue head has a memory operand.
- q_operand_size, in, 2: queue head operand size.
- q_is_integer, in, 1: queue head is an integer operation.
- q_is_bcd, in, 1: queue head is a BCD operation.
- q_data, in, 80: queue head operand data.
- dequeue, out, 1: combinational pop strobe to the queue.
- flush_queue, out, 1: one-cycle flush strobe to the queue.
- exec_start, out, 1: one-cycle start pulse to the NEU.
- exec_instruction, out, 8: issued opcode; held stable from ISSUE through WAIT.
- exec_stack_index, out, 3: issued stack index; held stable from ISSUE through WAIT.
- exec_has_memory_op, out, 1: issued memory-operand flag; held stable from ISSUE through WAIT.
- exec_operand_size, out, 2: issued operand size; held stable from ISSUE through WAIT.
- exec_is_integer, out, 1: issued integer flag; held stable from ISSUE through WAIT.
- exec_is_bcd, out, 1: issued BCD flag; held stable from ISSUE through WAIT.
- exec_data, out, 80: issued operand data; held stable from ISSUE through WAIT.
- exec_done, in, 1: NEU completion strobe.
- exec_error, in, 1: qualifies exec_done; 1 means the instruction faulted.
- busy, out, 1: state is not IDLE.
- exception_pending, out, 1: high while in HALT.
- exception_code, out, 2: 00 none, 01 execution error, 10 timeout.
- exception_clear, in, 1: releases HALT.
- retired_count, out, 16: number of instructions that completed without error; wraps at 65535.

Behaviour:
- Reset (synchronous, active-high) overrides everything, including mid-operation. Effects:
  - State goes to IDLE.
  - All issue registers clear to 0.
  - exec_start, flush_queue, exception_pending and busy are 0.
  - exception_code is 00; retired_count is 0; the watchdog counter is 0.
  - The NEU is expected to be reset by the same signal.
- States: IDLE, ISSUE, WAIT, FLUSH, HALT.
- IDLE:
  - dequeue = !queue_empty & dispatch_enable. It is 0 in every other state.
  - When dequeue=1, all q_* fields are latched into the issue registers on the same edge, and the next state is ISSUE.
- ISSUE:
  - exec_start=1 for exactly this cycle; the watchdog clears to 0; next state is WAIT.
  - exec_done is not sampled in ISSUE.
- WAIT:
  - The watchdog increments each cycle. exec_done takes priority over timeout in the same cycle.
  - exec_done & exec_error: assert flush_queue this cycle, set exception_code=01, go to HALT.
  - exec_done & !exec_error: retired_count+1. If exec_instruction is OPC_FINIT or OPC_FLDCW, go to FLUSH; otherwise go to IDLE.
  - !exec_done with watchdog == TIMEOUT_CYCLES-1: assert flush_queue, set exception_code=10, go to HALT.
- FLUSH: flush_queue=1 for one cycle, then go to IDLE. This drops younger entries fetched under the old control state.
- HALT:
  - exception_pending=1; no dequeue.
  - exception_clear=1 sets exception_code=00 and moves to IDLE on the next edge.
  - exception_clear outside HALT is ignored.
- Throughput: minimum 3 cycles per instruction (IDLE, ISSUE, then WAIT with an immediate done).
- Issue registers keep their last values after retire; they are only updated on dequeue.
- flush_queue is never asserted in the same cycle as dequeue.

Decomposition:
- Shared package fpu_dispatch_pkg holds:
  - state enum: IDLE=0, ISSUE=1, WAIT=2, FLUSH=3, HALT=4;
  - exception_code localparams: EXC_NONE, EXC_ERROR, EXC_TIMEOUT;
  - the default OPC_FINIT and OPC_FLDCW values.
- One sub-module, fpu_dispatch_watchdog: 16-bit counter with clear, enable and terminal-count output.
- All other logic stays in the top module.

Test Plan:
1. Basic issue: queue head 8'h10, q_data=80'h1234, queue_empty=0; NEU returns done 2 cycles after start.
   -> dequeue pulses one cycle; exec_start one cycle later; exec_data=80'h1234 held through WAIT; retired_count=1; back in IDLE.
2. Three entries back to back, NEU done immediately.
   -> three starts spaced 3 cycles apart; retired_count=3; no flush.
3. FINIT completes with 2 entries still queued.
   -> flush_queue high for one cycle after done; no further dequeue until the next IDLE cycle sees queue_empty=0.
4. exec_done with exec_error=1.
   -> flush_queue pulse; exception_pending=1; exception_code=01; retired_count unchanged.
   -> exception_clear returns the block to IDLE with code 00.
5. TIMEOUT_CYCLES=8, NEU never completes.
   -> flush_queue 8 cycles after exec_start; exception_code=10.
   -> exec_done asserted in the same cycle as terminal count instead: normal retire, no timeout.
6. Reset during WAIT, and dispatch_enable=0 with a non-empty queue.
   -> reset: all outputs at reset values next cycle.
   -> dispatch_enable=0: dequeue stays 0 while enable is low.
